// File: rtl/return_addr_stack_if.sv
// ---------------------------------------------------------------------------
// return_addr_stack_if
// Purpose : groups the decoder-side strobes, checkpoint controls and the
//           prediction outputs of one return-address stack instance.
// Signals :
//   dec_valid, pushCallStack, popCallStack, push_addr  - decoder strobes
//   chk_take, chk_id                                    - checkpoint capture
//   restore, restore_id                                 - mispredict repair
//   pop_valid, pop_addr                                 - predicted return target
//   tos, count, overflow                                - stack status
// Modports:
//   master - the decode/branch unit driving the stack
//   slave  - the return-address stack itself
// ---------------------------------------------------------------------------
interface return_addr_stack_if #(
  parameter int unsigned PTR_WIDTH = 4,
  parameter int unsigned IP_WIDTH  = 48,
  parameter int unsigned CHK_WIDTH = 3
);

  logic                 dec_valid;
  logic                 pushCallStack;
  logic                 popCallStack;
  logic [IP_WIDTH-1:0]  push_addr;
  logic                 chk_take;
  logic [CHK_WIDTH-1:0] chk_id;
  logic                 restore;
  logic [CHK_WIDTH-1:0] restore_id;
  logic                 pop_valid;
  logic [IP_WIDTH-1:0]  pop_addr;
  logic [PTR_WIDTH-1:0] tos;
  logic [PTR_WIDTH:0]   count;
  logic                 overflow;

  modport master (
    output dec_valid, pushCallStack, popCallStack, push_addr,
    output chk_take, chk_id, restore, restore_id,
    input  pop_valid, pop_addr, tos, count, overflow
  );

  modport slave (
    input  dec_valid, pushCallStack, popCallStack, push_addr,
    input  chk_take, chk_id, restore, restore_id,
    output pop_valid, pop_addr, tos, count, overflow
  );

endinterface

// File: rtl/return_addr_stack.sv
// ---------------------------------------------------------------------------
// return_addr_stack
// Purpose : speculative return-address stack fed by the jump decoder. Calls
//           push the return IP, rets pop a predicted target one cycle later.
//           Checkpoint slots capture the pointer state so a mispredict or
//           flush can repair tos/count.
// Ports   :
//   clk    - clock, all state changes on the rising edge
//   rst    - asynchronous active-high reset
//   io_bus - return_addr_stack_if.slave (decoder strobes, checkpoint
//            controls, pop_valid/pop_addr prediction, tos/count/overflow)
// Options :
//   RAS_PROTECT_TOS_EN - when defined, each checkpoint also saves the top
//                        entry and restore writes it back, undoing a
//                        wrong-path push that overwrote that entry.
// ---------------------------------------------------------------------------
module return_addr_stack #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_WIDTH = 4,
  parameter int unsigned IP_WIDTH  = 48,
  parameter int unsigned NCHK      = 8,
  parameter int unsigned CHK_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  return_addr_stack_if.slave   io_bus
);

  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  localparam logic [PTR_WIDTH-1:0] TOS_RST  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  // Architectural state
  logic [IP_WIDTH-1:0]  r_entry [DEPTH];
  logic [PTR_WIDTH-1:0] r_tos;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_pop_valid;
  logic [IP_WIDTH-1:0]  r_pop_addr;
  logic                 r_overflow;

  // Checkpoint slots
  logic [PTR_WIDTH-1:0] r_chk_tos   [NCHK];
  logic [CNT_WIDTH-1:0] r_chk_count [NCHK];
`ifdef RAS_PROTECT_TOS_EN
  logic [IP_WIDTH-1:0]  r_chk_top   [NCHK];
`endif

  // Decoded operations and next-state values
  logic                 w_push;
  logic                 w_pop;
  logic [PTR_WIDTH-1:0] w_tos_inc;
  logic [PTR_WIDTH-1:0] w_tos_dec;
  logic [IP_WIDTH-1:0]  w_top;
  logic [PTR_WIDTH-1:0] w_tos_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic                 w_pop_valid_nxt;
  logic [IP_WIDTH-1:0]  w_pop_addr_nxt;
  logic                 w_overflow_nxt;
  logic                 w_wr_en;
  logic [PTR_WIDTH-1:0] w_wr_idx;
  logic [IP_WIDTH-1:0]  w_wr_data;
  logic                 w_chk_wr;

  assign w_push    = io_bus.dec_valid & io_bus.pushCallStack;
  assign w_pop     = io_bus.dec_valid & io_bus.popCallStack;
  assign w_tos_inc = r_tos + PTR_ONE;
  assign w_tos_dec = r_tos - PTR_ONE;
  assign w_top     = r_entry[r_tos];

  // Next-state selection; restore takes priority over push/pop and chk_take
  always_comb begin
    w_tos_nxt       = r_tos;
    w_count_nxt     = r_count;
    w_pop_valid_nxt = 1'b0;
    w_pop_addr_nxt  = r_pop_addr;
    w_overflow_nxt  = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_idx        = r_tos;
    w_wr_data       = io_bus.push_addr;
    w_chk_wr        = 1'b0;

    if (io_bus.restore) begin
      w_tos_nxt   = r_chk_tos[io_bus.restore_id];
      w_count_nxt = r_chk_count[io_bus.restore_id];
`ifdef RAS_PROTECT_TOS_EN
      w_wr_en     = 1'b1;
      w_wr_idx    = r_chk_tos[io_bus.restore_id];
      w_wr_data   = r_chk_top[io_bus.restore_id];
`endif
    end else begin
      w_chk_wr = io_bus.chk_take;
      if (w_push && w_pop) begin
        // Swap: old top is predicted, new call replaces it in place
        w_pop_addr_nxt  = w_top;
        w_pop_valid_nxt = (r_count != '0);
        w_wr_en         = 1'b1;
        w_wr_idx        = r_tos;
        w_count_nxt     = (r_count == '0) ? CNT_ONE : r_count;
      end else if (w_push) begin
        w_tos_nxt = w_tos_inc;
        w_wr_en   = 1'b1;
        w_wr_idx  = w_tos_inc;
        if (r_count == CNT_FULL) begin
          // Full: the write lands on the oldest entry
          w_overflow_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + CNT_ONE;
        end
      end else if (w_pop) begin
        // Empty pop leaves pointers and pop_addr alone; fetch uses the BTB
        if (r_count != '0) begin
          w_pop_addr_nxt  = w_top;
          w_pop_valid_nxt = 1'b1;
          w_tos_nxt       = w_tos_dec;
          w_count_nxt     = r_count - CNT_ONE;
        end
      end
    end
  end

  // Pointer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tos       <= TOS_RST;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_pop_addr  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_tos       <= w_tos_nxt;
      r_count     <= w_count_nxt;
      r_pop_valid <= w_pop_valid_nxt;
      r_pop_addr  <= w_pop_addr_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  // Checkpoint capture of the pre-operation pointer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NCHK); i++) begin
        r_chk_tos[i]   <= TOS_RST;
        r_chk_count[i] <= '0;
`ifdef RAS_PROTECT_TOS_EN
        r_chk_top[i]   <= '0;
`endif
      end
    end else if (w_chk_wr) begin
      r_chk_tos[io_bus.chk_id]   <= r_tos;
      r_chk_count[io_bus.chk_id] <= r_count;
`ifdef RAS_PROTECT_TOS_EN
      r_chk_top[io_bus.chk_id]   <= w_top;
`endif
    end
  end

  // Entry storage: single write port, contents not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_entry[w_wr_idx] <= w_wr_data;
    end
  end

  assign io_bus.pop_valid = r_pop_valid;
  assign io_bus.pop_addr  = r_pop_addr;
  assign io_bus.tos       = r_tos;
  assign io_bus.count     = r_count;
  assign io_bus.overflow  = r_overflow;

endmodule
